instr_beat_loader: RTL and testbench

//  Parametrised push-button instruction loader. It assembles an INSTR_W-bit instruction

---
 rtl/instr_beat_loader.sv | 172 +++++++++++++++++
 tb/tb_instr_beat_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_beat_loader.sv
// Push-button instruction loader: assembles INSTR_W-bit words from DATA_W-bit beats, one per press.
// Optional press debouncing is enabled by defining DEBOUNCE_EN.
module instr_beat_loader #(
  parameter int DATA_W       = 8,
  parameter int INSTR_W      = 16,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   btn_in,
  input  logic                                                   abort_in,
  input  logic [DATA_W-1:0]                                      data_in,
  output logic [INSTR_W-1:0]                                     instr_out,
  output logic                                                   instr_valid,
  input  logic                                                   instr_ready,
  output logic [$clog2((INSTR_W + DATA_W - 1) / DATA_W)-1:0]     beat_idx,
  output logic                                                   btn_pulse,
  output logic                                                   dropped
);

  localparam int BEATS = (INSTR_W + DATA_W - 1) / DATA_W;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  logic btn_sync_p0;
  logic btn_sync_p1;
  logic abort_sync_p0;
  logic abort_sync_p1;
  logic btn_stable;
  logic btn_prev_p2;
  logic btn_pulse_p2;

  state_t               state;
  state_t               state_d;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_d;
  logic [INSTR_W-1:0]   instr;
  logic [INSTR_W-1:0]   instr_d;
  logic                 dropped_r;
  logic                 dropped_d;

  // Overwrite beat k of the current word; the final beat is clipped to the word width.
  function automatic logic [INSTR_W-1:0] merge_beat(
    input logic [INSTR_W-1:0] cur,
    input logic [DATA_W-1:0]  d,
    input logic [IDX_W-1:0]   k
  );
    logic [INSTR_W-1:0] mask;
    logic [INSTR_W-1:0] val;
    int                 sh;
    sh   = int'(k) * DATA_W;
    mask = INSTR_W'({DATA_W{1'b1}}) << sh;
    val  = INSTR_W'(d) << sh;
    return (cur & ~mask) | (val & mask);
  endfunction

  // Stage p0/p1: two-flop synchronisers for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_sync_p0   <= 1'b0;
      btn_sync_p1   <= 1'b0;
      abort_sync_p0 <= 1'b0;
      abort_sync_p1 <= 1'b0;
    end else begin
      btn_sync_p0   <= btn_in;
      btn_sync_p1   <= btn_sync_p0;
      abort_sync_p0 <= abort_in;
      abort_sync_p1 <= abort_sync_p0;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             db_level;

  // Level follows the synced button only after DEBOUNCE_CYC consecutive mismatching cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (btn_sync_p1 == db_level) begin
      db_cnt   <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
      db_cnt   <= '0;
      db_level <= btn_sync_p1;
    end else begin
      db_cnt   <= db_cnt + CNT_W'(1);
    end
  end

  assign btn_stable = db_level;
`else
  assign btn_stable = btn_sync_p1;
`endif

  // Stage p2: rising-edge detect on the stable level, registered so capture lands one edge later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_prev_p2  <= 1'b0;
      btn_pulse_p2 <= 1'b0;
    end else begin
      btn_prev_p2  <= btn_stable;
      btn_pulse_p2 <= btn_stable & ~btn_prev_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      instr     <= '0;
      dropped_r <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      instr     <= instr_d;
      dropped_r <= dropped_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    instr_d   = instr;
    dropped_d = dropped_r | (btn_pulse_p2 && (state == HOLD));
    case (state)
      COLLECT: begin
        if (abort_sync_p1) begin
          idx_d   = '0;
          instr_d = '0;
        end else if (btn_pulse_p2) begin
          instr_d = merge_beat(instr, data_in, idx);
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d   = idx + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        // Abort voids any handshake offered in the same cycle.
        if (abort_sync_p1) begin
          state_d = COLLECT;
          idx_d   = '0;
          instr_d = '0;
        end else if (instr_ready) begin
          state_d = COLLECT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    endcase
  end

  assign instr_out   = instr;
  assign instr_valid = (state == HOLD);
  assign beat_idx    = idx;
  assign btn_pulse   = btn_pulse_p2;
  assign dropped     = dropped_r;

endmodule

// File: tb/tb_instr_beat_loader.sv
// Directed bench for instr_beat_loader: a default 16-bit loader and a 12-bit variant side by side.
`timescale 1ns/1ps
module tb_instr_beat_loader;

`ifdef DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        btn_a, abort_a, ready_a;
  logic [7:0]  data_a;
  logic [15:0] instr_a;
  logic        valid_a, idx_a, pulse_a, dropped_a;

  logic        btn_b, abort_b, ready_b;
  logic [7:0]  data_b;
  logic [11:0] instr_b;
  logic        valid_b, idx_b, pulse_b, dropped_b;

  int checks = 0;
  int errors = 0;
  int pulses_a = 0;
  int p0;

  instr_beat_loader #(.DATA_W(8), .INSTR_W(16), .DEBOUNCE_CYC(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_a), .abort_in(abort_a), .data_in(data_a),
    .instr_out(instr_a), .instr_valid(valid_a), .instr_ready(ready_a),
    .beat_idx(idx_a), .btn_pulse(pulse_a), .dropped(dropped_a)
  );

  instr_beat_loader #(.DATA_W(8), .INSTR_W(12), .DEBOUNCE_CYC(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_b), .abort_in(abort_b), .data_in(data_b),
    .instr_out(instr_b), .instr_valid(valid_b), .instr_ready(ready_b),
    .beat_idx(idx_b), .btn_pulse(pulse_b), .dropped(dropped_b)
  );

  always @(posedge clk) if (pulse_a === 1'b1) pulses_a <= pulses_a + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_a(input logic [7:0] d);
    data_a = d;
    btn_a  = 1'b1;
    repeat (DB + 4) step();
    btn_a  = 1'b0;
    repeat (DB + 6) step();
  endtask

  task automatic press_b(input logic [7:0] d);
    data_b = d;
    btn_b  = 1'b1;
    repeat (DB + 4) step();
    btn_b  = 1'b0;
    repeat (DB + 6) step();
  endtask

  initial begin
    rst_n = 1'b0;
    btn_a = 0; abort_a = 0; ready_a = 0; data_a = '0;
    btn_b = 0; abort_b = 0; ready_b = 0; data_b = '0;
    repeat (3) step();
    check("rst_instr",   instr_a,   32'h0);
    check("rst_valid",   valid_a,   32'h0);
    check("rst_idx",     idx_a,     32'h0);
    check("rst_pulse",   pulse_a,   32'h0);
    check("rst_dropped", dropped_a, 32'h0);
    check("rst_instr_b", instr_b,   32'h0);
    rst_n = 1'b1;
    step();

    // First beat with edge-accurate timing: btn sampled at edge N.
    data_a = 8'h12;
    btn_a  = 1'b1;
    repeat (DB + 2) step();
    check("pulse_early", pulse_a, 32'h0);
    step();
    check("pulse_edge",  pulse_a, 32'h1);
    check("idx_precap",  idx_a,   32'h0);
    step();
    check("idx_postcap", idx_a,   32'h1);
    check("beat0",       instr_a, 32'h0012);
    check("pulse_one",   pulse_a, 32'h0);
    btn_a = 1'b0;
    repeat (DB + 6) step();

    press_a(8'h34);
    check("t1_valid", valid_a, 32'h1);
    check("t1_instr", instr_a, 32'h3412);
    check("t1_idx",   idx_a,   32'h0);
    check("t1_drop",  dropped_a, 32'h0);

    press_a(8'hFF);
    check("t2_dropped", dropped_a, 32'h1);
    check("t2_instr",   instr_a,   32'h3412);
    check("t2_valid",   valid_a,   32'h1);
    check("t2_pulses",  pulses_a,  32'd3);
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    check("t2_hs_valid", valid_a, 32'h0);
    check("t2_hs_idx",   idx_a,   32'h0);
    check("t2_hs_keep",  instr_a, 32'h3412);

    press_b(8'hAB);
    check("t3_idx",   idx_b,   32'h1);
    check("t3_beat0", instr_b, 32'h0AB);
    press_b(8'hCD);
    check("t3_instr", instr_b, 32'hDAB);
    check("t3_valid", valid_b, 32'h1);

    press_a(8'h55);
    check("t4_partial", instr_a, 32'h3455);
    check("t4_idx1",    idx_a,   32'h1);
    abort_a = 1'b1;
    data_a  = 8'h99;
    btn_a   = 1'b1;
    repeat (DB + 4) step();
    abort_a = 1'b0;
    step();
    btn_a   = 1'b0;
    repeat (DB + 6) step();
    check("t4_abort_idx",   idx_a,   32'h0);
    check("t4_abort_instr", instr_a, 32'h0);
    check("t4_abort_valid", valid_a, 32'h0);
    press_a(8'h01);
    press_a(8'h02);
    check("t4_instr", instr_a, 32'h0201);
    check("t4_valid", valid_a, 32'h1);

    // Abort in HOLD coinciding with instr_ready: handshake is void.
    abort_a = 1'b1;
    step();
    step();
    check("hold_abort_pre", valid_a, 32'h1);
    ready_a = 1'b1;
    step();
    check("hold_abort_valid", valid_a, 32'h0);
    check("hold_abort_instr", instr_a, 32'h0);
    ready_a = 1'b0;
    abort_a = 1'b0;
    repeat (4) step();

    ready_a = 1'b1;
    press_a(8'h77);
    check("ready_ignored_idx",   idx_a,   32'h1);
    check("ready_ignored_instr", instr_a, 32'h0077);
    ready_a = 1'b0;

    rst_n = 1'b0;
    step();
    step();
    check("t6_instr",   instr_a,   32'h0);
    check("t6_valid",   valid_a,   32'h0);
    check("t6_idx",     idx_a,     32'h0);
    check("t6_pulse",   pulse_a,   32'h0);
    check("t6_dropped", dropped_a, 32'h0);
    rst_n = 1'b1;
    step();
    press_a(8'h11);
    press_a(8'h22);
    check("t6_fresh", instr_a, 32'h2211);
    check("t6_fvld",  valid_a, 32'h1);

`ifdef DEBOUNCE_EN
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    step();
    p0 = pulses_a;
    btn_a = 1'b1;
    repeat (10) step();
    btn_a = 1'b0;
    repeat (30) step();
    check("t5_glitch_pulses", pulses_a - p0, 32'd0);
    check("t5_glitch_idx",    idx_a,         32'h0);
    p0 = pulses_a;
    data_a = 8'h5A;
    btn_a  = 1'b1;
    repeat (DB + 3) step();
    check("t5_precap", idx_a, 32'h0);
    step();
    check("t5_cap_n19", idx_a, 32'h1);
    repeat (40 - (DB + 4)) step();
    btn_a = 1'b0;
    repeat (30) step();
    check("t5_one_pulse", pulses_a - p0, 32'd1);
    check("t5_instr",     instr_a,       32'h225A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
